inv_keygen_seq: RTL and testbench

- Iterative AES-128 inverse key-schedule engine for the decryption datapath.
- Takes the final (round-10) round key and emits round keys in descending order, NUM_ROUNDS down to 0, one per output handshake.
- Runs the forward key-expansion recurrence backwards, so the decrypt round loop receives keys in the order it consumes them without storing the whole schedule.
- Sits between key load and the inverse-cipher round controller.

---
 rtl/inv_keygen_seq.sv | 131 +++++++++++++
 tb/tb_inv_keygen_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_keygen_seq.sv
// AES-128 inverse key-schedule engine: walks the key expansion backwards from
// the last round key, emitting one round key per output handshake.
//   state | meaning
//   IDLE  | no schedule owned, waiting for start
//   EMIT  | presenting key_out for key_round, advancing on each handshake
module inv_keygen_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] key_last,
  input  logic         key_ready,
  output logic [0:127] key_out,
  output logic [0:3]   key_round,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
    $error("inv_keygen_seq: NUM_ROUNDS must be in 1..10");
  end

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t        state, state_nxt;
  logic [0:127]  key_nxt, prev_key;
  logic [0:3]    round_nxt;
  logic          valid_nxt, busy_nxt, done_nxt;
  logic [0:31]   w0, w1, w2, w3, p0, p1, p2, p3, rot, sub;

  // p0 depends on the freshly recovered p3, not w3: XOR then S-box is the long path.
  always_comb begin
    w0  = key_out[0:31];
    w1  = key_out[32:63];
    w2  = key_out[64:95];
    w3  = key_out[96:127];
    p3  = w3 ^ w2;
    p2  = w2 ^ w1;
    p1  = w1 ^ w0;
    rot = {p3[8:31], p3[0:7]};
    sub = {sbox(rot[0:7]), sbox(rot[8:15]), sbox(rot[16:23]), sbox(rot[24:31])};
    p0  = w0 ^ sub ^ {rcon(key_round), 24'h000000};
    prev_key = {p0, p1, p2, p3};
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_out;
    round_nxt = key_round;
    valid_nxt = key_valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_nxt   = key_last;
          round_nxt = 4'(NUM_ROUNDS);
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (key_round != 4'd0) begin
            key_nxt   = prev_key;
            round_nxt = key_round - 4'd1;
          end else begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_out   <= '0;
      key_round <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_out   <= key_nxt;
      key_round <= round_nxt;
      key_valid <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_inv_keygen_seq.sv
// Bench for inv_keygen_seq: scoreboard of expected round keys checked every
// cycle, plus a NUM_ROUNDS=1 instance exercised by a short hand sequence.
module tb_inv_keygen_seq;

  localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk, rst_n;
  logic         start, key_ready, key_valid, busy, done;
  logic [0:127] key_last, key_out;
  logic [0:3]   key_round;
  logic         start1, key_ready1, key_valid1, busy1, done1;
  logic [0:127] key_last1, key_out1;
  logic [0:3]   key_round1;

  inv_keygen_seq #(.NUM_ROUNDS(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_last(key_last), .key_ready(key_ready),
    .key_out(key_out), .key_round(key_round), .key_valid(key_valid), .busy(busy), .done(done)
  );

  inv_keygen_seq #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_last(key_last1), .key_ready(key_ready1),
    .key_out(key_out1), .key_round(key_round1), .key_valid(key_valid1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
    bit           chk;
  } exp_t;

  typedef struct {
    logic [127:0] key;
    int           pct;
    bit           stall;
    logic [127:0] r0;
  } tv_t;

  exp_t         sb_q[$];
  logic [127:0] fips_rk [0:10];
  tv_t          tv [4];
  logic [127:0] last_r0;
  bit           done_exp;
  int           n_vec, n_fail;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sched(input logic [127:0] k);
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      if (k == FIPS10) begin
        e.key = fips_rk[r];
        e.chk = 1'b1;
      end else begin
        e.key = (r == 10) ? k : 128'h0;
        e.chk = (r == 10) || (r == 0 && k == ZERO10);
      end
      sb_q.push_back(e);
    end
  endtask

  // Model step at the falling edge: compare, then advance on the model's own handshake.
  task automatic sb_step();
    exp_t e;
    bit   accept, nd;
    if (!rst_n) begin
      sb_q.delete();
      done_exp = 1'b0;
    end else begin
      accept = start && (sb_q.size() == 0);
      chk("key_valid", {127'b0, key_valid}, {127'b0, sb_q.size() != 0});
      chk("busy", {127'b0, busy}, {127'b0, sb_q.size() != 0});
      chk("done", {127'b0, done}, {127'b0, done_exp});
      nd = 1'b0;
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        chk("key_round", {124'b0, key_round}, {124'b0, e.rnd});
        if (e.chk) chk("key_out", key_out, e.key);
        if (key_ready) begin
          void'(sb_q.pop_front());
          if (e.rnd == 4'd0) begin
            nd = 1'b1;
            last_r0 = key_out;
          end
        end
      end
      done_exp = nd;
      if (accept) push_sched(key_last);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int pct);
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 300) begin
      key_ready = ($urandom_range(0, 99) < pct);
      cyc();
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: %0d keys still outstanding after %0d cycles", sb_q.size(), guard);
      sb_q.delete();
    end
    key_ready = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic run_sched(input logic [127:0] k, input int pct, input bit stall);
    start = 1'b1; key_last = k; key_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    if (stall) begin
      key_ready = 1'b0;
      repeat (5) cyc();
    end
    wait_empty(pct);
  endtask

  initial begin
    n_vec = 0; n_fail = 0; done_exp = 1'b0; last_r0 = '1;
    fips_rk[0]  = FIPS0;
    fips_rk[1]  = FIPS1;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = FIPS10;
    tv[0] = '{key: FIPS10, pct: 100, stall: 1'b0, r0: FIPS0};
    tv[1] = '{key: FIPS10, pct: 60,  stall: 1'b1, r0: FIPS0};
    tv[2] = '{key: ZERO10, pct: 70,  stall: 1'b0, r0: 128'h0};
    tv[3] = '{key: ZERO10, pct: 100, stall: 1'b0, r0: 128'h0};

    rst_n = 1'b0; start = 1'b0; key_last = '0; key_ready = 1'b1;
    start1 = 1'b0; key_last1 = '0; key_ready1 = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("reset key_out", key_out, 128'h0);
    chk("reset key_round", {124'b0, key_round}, 128'h0);
    chk("reset flags", {125'b0, key_valid, busy, done}, 128'h0);
    chk("reset1 flags", {125'b0, key_valid1, busy1, done1}, 128'h0);
    cyc();

    for (int i = 0; i < 4; i++) begin
      last_r0 = '1;
      run_sched(tv[i].key, tv[i].pct, tv[i].stall);
      chk($sformatf("round0 vec%0d", i), last_r0, tv[i].r0);
    end

    // start pulses at round 5 and in the final-handshake cycle must be ignored;
    // the one held into the done cycle is accepted.
    start = 1'b1; key_last = FIPS10; key_ready = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    chk("round at ignored start", {124'b0, key_round}, 128'd5);
    start = 1'b1; key_last = ZERO10;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("final handshake round", {124'b0, key_round}, 128'd0);
    start = 1'b1; key_last = ZERO10;
    cyc();
    chk("done cycle", {127'b0, done}, 128'd1);
    cyc();
    start = 1'b0;
    chk("restart key", key_out, ZERO10);
    chk("restart round", {124'b0, key_round}, 128'd10);
    wait_empty(100);

    // reset while emitting round 6
    start = 1'b1; key_last = FIPS10; key_ready = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("round before reset", {124'b0, key_round}, 128'd6);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid reset key_out", key_out, 128'h0);
    chk("mid reset key_round", {124'b0, key_round}, 128'h0);
    chk("mid reset flags", {125'b0, key_valid, busy, done}, 128'h0);
    repeat (3) cyc();
    last_r0 = '1;
    run_sched(FIPS10, 100, 1'b0);
    chk("round0 after reset", last_r0, FIPS0);

    // NUM_ROUNDS=1 instance
    start1 = 1'b1; key_last1 = FIPS1; key_ready1 = 1'b1;
    cyc();
    start1 = 1'b0;
    chk("n1 first key", key_out1, FIPS1);
    chk("n1 first round", {124'b0, key_round1}, 128'd1);
    chk("n1 first flags", {125'b0, key_valid1, busy1, done1}, 128'b110);
    cyc();
    chk("n1 round0 key", key_out1, FIPS0);
    chk("n1 round0 round", {124'b0, key_round1}, 128'd0);
    chk("n1 round0 flags", {125'b0, key_valid1, busy1, done1}, 128'b110);
    cyc();
    chk("n1 done flags", {125'b0, key_valid1, busy1, done1}, 128'b001);
    cyc();
    chk("n1 idle flags", {125'b0, key_valid1, busy1, done1}, 128'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
